// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC3 single-port memory controller and IF/D arbiter
//
// Shares one synchronous memory port between instruction fetch (if_*) and
// load/store (d_*). One transaction outstanding, fixed latency MEM_LAT,
// data-priority arbitration with a starvation counter that forces a fetch
// grant after STARVE_MAX consecutive contested losses.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch grant and read response
//   d_req/d_we/d_addr/d_wdata   data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata      data grant and response (rdata 0 on writes)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   busy                        high while not IDLE
// Optional macro LC3_MEM_CTRL_MMIO_EN adds io_en/io_we/io_addr/io_wdata/io_rdata;
// D accesses at or above 16'hFE00 then use the io port with 1-cycle latency.

module lc3_mem_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef LC3_MEM_CTRL_MMIO_EN
  output logic              io_en,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;
  logic [3:0]  starve_q, starve_n;
  logic        owner_q, owner_n;   // 1 = D owns the transaction, 0 = IF
  logic        we_q, we_n;
  logic        io_q, io_n;         // transaction targets the io port

  logic              if_gnt_n, d_gnt_n, if_rvalid_n, d_rvalid_n;
  logic [DATA_W-1:0] if_rdata_n, d_rdata_n;
  logic              mem_en_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              busy_n;

  logic              pick_if;
  logic              d_is_io;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic [DATA_W-1:0] rsp_data;

`ifdef LC3_MEM_CTRL_MMIO_EN
  logic              io_en_n, io_we_n;
  logic [ADDR_W-1:0] io_addr_n;
  logic [DATA_W-1:0] io_wdata_n;

  assign d_is_io  = (d_addr >= 16'hFE00);
  assign rsp_data = io_q ? io_rdata : mem_rdata;
`else
  assign d_is_io  = 1'b0;
  assign rsp_data = mem_rdata;
`endif

  // D has priority unless IF has lost STARVE_MAX contested rounds in a row.
  assign pick_if   = if_req && (!d_req || (starve_q == 4'(STARVE_MAX)));
  assign sel_addr  = pick_if ? if_addr : d_addr;
  assign sel_wdata = pick_if ? '0 : d_wdata;
  assign sel_we    = pick_if ? 1'b0 : d_we;

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    starve_n    = starve_q;
    owner_n     = owner_q;
    we_n        = we_q;
    io_n        = io_q;
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    if_rvalid_n = 1'b0;
    d_rvalid_n  = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
`ifdef LC3_MEM_CTRL_MMIO_EN
    io_en_n     = 1'b0;
    io_we_n     = 1'b0;
    io_addr_n   = io_addr;
    io_wdata_n  = io_wdata;
`endif

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_n = ISSUE;
          owner_n = !pick_if;
          we_n    = sel_we;
          io_n    = !pick_if && d_is_io;
          if (pick_if) begin
            if_gnt_n = 1'b1;
            starve_n = '0;
          end else begin
            d_gnt_n = 1'b1;
            // A contested D win implies starve_q < STARVE_MAX, so no overflow.
            if (if_req) starve_n = starve_q + 4'd1;
          end
          // Grant and strobe are registered here so they are seen in ISSUE.
          if (!pick_if && d_is_io) begin
`ifdef LC3_MEM_CTRL_MMIO_EN
            io_en_n    = 1'b1;
            io_we_n    = sel_we;
            io_addr_n  = sel_addr;
            io_wdata_n = sel_wdata;
`endif
          end else begin
            mem_en_n    = 1'b1;
            mem_we_n    = sel_we;
            mem_addr_n  = sel_addr;
            mem_wdata_n = sel_wdata;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = io_q ? 4'd0 : 4'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_n = RESP;
          if (owner_q) begin
            d_rvalid_n = 1'b1;
            d_rdata_n  = we_q ? '0 : rsp_data;
          end else begin
            if_rvalid_n = 1'b1;
            if_rdata_n  = rsp_data;
          end
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef LC3_MEM_CTRL_MMIO_EN
      io_en     <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
`endif
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      starve_q  <= starve_n;
      owner_q   <= owner_n;
      we_q      <= we_n;
      io_q      <= io_n;
      if_gnt    <= if_gnt_n;
      d_gnt     <= d_gnt_n;
      if_rvalid <= if_rvalid_n;
      d_rvalid  <= d_rvalid_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      busy      <= busy_n;
`ifdef LC3_MEM_CTRL_MMIO_EN
      io_en     <= io_en_n;
      io_we     <= io_we_n;
      io_addr   <= io_addr_n;
      io_wdata  <= io_wdata_n;
`endif
    end
  end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - scoreboard testbench for lc3_mem_ctrl

module tb_lc3_mem_ctrl;

  localparam int L    = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [15:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
`ifdef LC3_MEM_CTRL_MMIO_EN
  logic        io_en, io_we;
  logic [15:0] io_addr, io_wdata, io_rdata;
`endif

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef LC3_MEM_CTRL_MMIO_EN
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata),
`endif
    .busy(busy)
  );

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
  } exp_t;

  exp_t q_gnt[$];
  exp_t q_ifr[$];
  exp_t q_dr[$];
  exp_t q_mem[$];

  function automatic exp_t mk(input int c, input logic [15:0] a, input logic [15:0] b, input logic we);
    exp_t e;
    e.cyc = c;
    e.a   = a;
    e.b   = b;
    e.we  = we;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: read data appears MEM_LAT cycles after the mem_en cycle.
  logic [15:0] memarr [logic [15:0]];
  logic [15:0] pipe [0:L];

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (memarr.exists(a)) return memarr[a];
    return 16'h0BAD;
  endfunction

  always @(negedge clk) begin
    for (int i = L; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = (mem_en && !mem_we) ? rd(mem_addr) : 16'hDEAD;
    if (mem_en && mem_we) memarr[mem_addr] = mem_wdata;
    mem_rdata = pipe[L];
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if ($isunknown({if_req, d_req})) begin
        errors++;
        $display("FAIL x_on_req actual=%b expected=known (cycle %0d)", {if_req, d_req}, cyc);
      end
      if (if_gnt || d_gnt) begin
        if (q_gnt.size() == 0) check("gnt_unexpected", 64'({d_gnt, if_gnt}), 64'(0));
        else begin
          e = q_gnt.pop_front();
          check("gnt_cycle", 64'(cyc), 64'(e.cyc));
          check("gnt_who", 64'({d_gnt, if_gnt}), 64'(e.a));
        end
      end
      if (if_rvalid) begin
        if (q_ifr.size() == 0) check("if_rvalid_unexpected", 64'(if_rvalid), 64'(0));
        else begin
          e = q_ifr.pop_front();
          check("if_rvalid_cycle", 64'(cyc), 64'(e.cyc));
          check("if_rdata", 64'(if_rdata), 64'(e.a));
        end
      end
      if (d_rvalid) begin
        if (q_dr.size() == 0) check("d_rvalid_unexpected", 64'(d_rvalid), 64'(0));
        else begin
          e = q_dr.pop_front();
          check("d_rvalid_cycle", 64'(cyc), 64'(e.cyc));
          check("d_rdata", 64'(d_rdata), 64'(e.a));
        end
      end
      if (mem_en) begin
        if (q_mem.size() == 0) check("mem_en_unexpected", 64'(mem_en), 64'(0));
        else begin
          e = q_mem.pop_front();
          check("mem_cycle", 64'(cyc), 64'(e.cyc));
          check("mem_we", 64'(mem_we), 64'(e.we));
          check("mem_addr", 64'(mem_addr), 64'(e.a));
          if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.b));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}), 64'(0));
    check({tag, "_data"}, 64'({if_rdata, d_rdata, mem_addr}), 64'(0));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  // One uncontested request; returns with the DUT back in IDLE.
  task automatic single(input logic is_d, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata);
    int c;
    c = cyc;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      q_gnt.push_back(mk(c + 1, 16'h2, 16'h0, 1'b0));
      q_dr.push_back(mk(c + 2 + L, rdata, 16'h0, 1'b0));
    end else begin
      if_req = 1'b1; if_addr = addr;
      q_gnt.push_back(mk(c + 1, 16'h1, 16'h0, 1'b0));
      q_ifr.push_back(mk(c + 2 + L, rdata, 16'h0, 1'b0));
    end
    q_mem.push_back(mk(c + 1, addr, wdata, we));
    for (int i = 1; i <= L + 3; i++) begin
      tick;
      if (i == 2) begin if_req = 1'b0; d_req = 1'b0; end
      check("busy", 64'(busy), 64'(i <= L + 2));
    end
  endtask

  // Both requesters held; who[k] = 1 means the k-th grant goes to D.
  task automatic contested(input int n, input logic [7:0] who);
    int c;
    c = cyc;
    if_req = 1'b1; if_addr = 16'h3000;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h4000; d_wdata = 16'h0;
    for (int k = 0; k < n; k++) begin
      int g;
      g = c + 1 + k * (L + 3);
      if (who[k]) begin
        q_gnt.push_back(mk(g, 16'h2, 16'h0, 1'b0));
        q_mem.push_back(mk(g, 16'h4000, 16'h0, 1'b0));
        q_dr.push_back(mk(g + L + 1, 16'h4444, 16'h0, 1'b0));
      end else begin
        q_gnt.push_back(mk(g, 16'h1, 16'h0, 1'b0));
        q_mem.push_back(mk(g, 16'h3000, 16'h0, 1'b0));
        q_ifr.push_back(mk(g + L + 1, 16'h1234, 16'h0, 1'b0));
      end
    end
    for (int i = 1; i <= (n - 1) * (L + 3) + L + 3; i++) begin
      tick;
      if (i == (n - 1) * (L + 3) + 2) begin if_req = 1'b0; d_req = 1'b0; end
    end
  endtask

  initial begin
    int c;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    mem_rdata = 16'h0;
`ifdef LC3_MEM_CTRL_MMIO_EN
    io_rdata = 16'h8000;
`endif
    for (int i = 0; i <= L; i++) pipe[i] = 16'hDEAD;
    memarr[16'h3000] = 16'h1234;
    memarr[16'h3002] = 16'h5678;
    memarr[16'h4000] = 16'h4444;

    repeat (3) tick;
    check_all_zero("reset");
    rst = 1'b0;
    tick;

    single(1'b0, 1'b0, 16'h3000, 16'h0,    16'h1234);
    single(1'b1, 1'b1, 16'h5000, 16'hBEEF, 16'h0000);
    single(1'b1, 1'b0, 16'h5000, 16'h0,    16'hBEEF);
    single(1'b0, 1'b0, 16'h3002, 16'h0,    16'h5678);

    // Contested once: D wins, IF follows when D drops.
    c = cyc;
    if_req = 1'b1; if_addr = 16'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4000;
    q_gnt.push_back(mk(c + 1, 16'h2, 16'h0, 1'b0));
    q_mem.push_back(mk(c + 1, 16'h4000, 16'h0, 1'b0));
    q_dr.push_back(mk(c + 4, 16'h4444, 16'h0, 1'b0));
    q_gnt.push_back(mk(c + 6, 16'h1, 16'h0, 1'b0));
    q_mem.push_back(mk(c + 6, 16'h3000, 16'h0, 1'b0));
    q_ifr.push_back(mk(c + 9, 16'h1234, 16'h0, 1'b0));
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (i == 2) d_req = 1'b0;
      if (i == 7) if_req = 1'b0;
    end

    // Starvation from 0: D D D D IF D.
    contested(6, 8'b10_1111);
    // Uncontested D leaves starvation count at 1: then D D D IF.
    single(1'b1, 1'b0, 16'h4000, 16'h0, 16'h4444);
    contested(4, 8'b0111);

    // Reset in the cycle after a grant aborts the fetch.
    c = cyc;
    if_req = 1'b1; if_addr = 16'h3000;
    q_gnt.push_back(mk(c + 1, 16'h1, 16'h0, 1'b0));
    q_mem.push_back(mk(c + 1, 16'h3000, 16'h0, 1'b0));
    tick;
    tick;
    if_req = 1'b0;
    rst = 1'b1;
    tick;
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (L + 2) tick;
    single(1'b0, 1'b0, 16'h3002, 16'h0, 16'h5678);

`ifdef LC3_MEM_CTRL_MMIO_EN
    c = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFE02;
    q_gnt.push_back(mk(c + 1, 16'h2, 16'h0, 1'b0));
    q_dr.push_back(mk(c + 3, 16'h8000, 16'h0, 1'b0));
    tick;
    check("io_en", 64'(io_en), 64'(1));
    check("io_addr", 64'(io_addr), 64'(16'hFE02));
    tick;
    d_req = 1'b0;
    repeat (3) tick;
`endif

    repeat (3) tick;
    check("q_gnt_empty", 64'(q_gnt.size()), 64'(0));
    check("q_ifr_empty", 64'(q_ifr.size()), 64'(0));
    check("q_dr_empty", 64'(q_dr.size()), 64'(0));
    check("q_mem_empty", 64'(q_mem.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
